// File: rtl/shift_rotate_unit.sv
// shift_rotate_unit: two-stage shift/rotate pipeline with valid/ready handshakes.
// S1 captures the request and its effective count; S2 holds the result and flags.
// Flag generation ({OF,SF,ZF,PF,CF} and per-flag update mask) is compiled in only
// when SHIFT_ROTATE_FLAGS_EN is defined; otherwise out_flags/out_fmask are tied to 0.
module shift_rotate_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [7:0]       in_cnt,
  input  logic             in_cf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic [4:0]       out_flags,
  output logic [4:0]       out_fmask
);

  typedef enum logic [2:0] {
    OP_ROL = 3'b000,
    OP_ROR = 3'b001,
    OP_RCL = 3'b010,
    OP_RCR = 3'b011,
    OP_SHL = 3'b100,
    OP_SHR = 3'b101,
    OP_SAL = 3'b110,
    OP_SAR = 3'b111
  } op_e;

  localparam logic [7:0] W8   = 8'(WIDTH);
  localparam logic [7:0] W8P1 = 8'(WIDTH + 1);

  logic             s1_valid;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic             s1_cf;
  logic [7:0]       s1_cnt;

  logic             s2_free;
  op_e              in_op_e;
  logic [7:0]       in_eff;
  logic [WIDTH-1:0] res_r;
  logic [4:0]       flags_d;
  logic [4:0]       fmask_d;

  assign in_op_e  = op_e'(in_op);
  assign s2_free  = !out_valid || out_ready;
  assign in_ready = rst_n && (!s1_valid || s2_free);

  // Reduce the raw count to the effective count for the requested operation
  always_comb begin
    unique case (in_op_e)
      OP_ROL, OP_ROR: in_eff = in_cnt % W8;
      OP_RCL, OP_RCR: in_eff = in_cnt % W8P1;
      default:        in_eff = (in_cnt > W8P1) ? W8P1 : in_cnt;
    endcase
  end

  // Stage 1 register: load when the stage is empty or draining into S2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ROL;
      s1_a     <= '0;
      s1_cf    <= 1'b0;
      s1_cnt   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op  <= in_op_e;
        s1_a   <= in_a;
        s1_cf  <= in_cf;
        s1_cnt <= in_eff;
      end
    end
  end

  // Result datapath; every form degenerates to s1_a when the effective count is 0
  always_comb begin
    res_r = s1_a;
    unique case (s1_op)
      OP_ROL: res_r = (s1_a << s1_cnt) | (s1_a >> (W8 - s1_cnt));
      OP_ROR: res_r = (s1_a >> s1_cnt) | (s1_a << (W8 - s1_cnt));
      OP_RCL: res_r = WIDTH'(({s1_cf, s1_a} << s1_cnt) | ({s1_cf, s1_a} >> (W8P1 - s1_cnt)));
      OP_RCR: res_r = WIDTH'(({s1_cf, s1_a} >> s1_cnt) | ({s1_cf, s1_a} << (W8P1 - s1_cnt)));
      OP_SHL, OP_SAL: res_r = s1_a << s1_cnt;
      OP_SHR: res_r = s1_a >> s1_cnt;
      OP_SAR: res_r = $unsigned($signed(s1_a) >>> s1_cnt);
    endcase
  end

`ifdef SHIFT_ROTATE_FLAGS_EN
  localparam int unsigned CW = $clog2(WIDTH);

  logic [CW-1:0] hi_idx;
  logic [CW-1:0] lo_idx;
  logic          cf_out;
  logic          of_out;
  logic          is_shift;

  // Carry is taken straight from the operand bit that left last (a[W-c] for
  // left moves, a[c-1] for right moves) instead of widening the datapath
  always_comb begin
    hi_idx   = CW'(W8 - s1_cnt);
    lo_idx   = CW'(s1_cnt - 8'd1);
    cf_out   = s1_cf;
    of_out   = 1'b0;
    is_shift = 1'b0;
    unique case (s1_op)
      OP_ROL: begin
        cf_out = res_r[0];
        of_out = res_r[WIDTH-1] ^ res_r[0];
      end
      OP_ROR: begin
        cf_out = res_r[WIDTH-1];
        of_out = res_r[WIDTH-1] ^ res_r[WIDTH-2];
      end
      OP_RCL: begin
        cf_out = s1_a[hi_idx];
        of_out = res_r[WIDTH-1] ^ s1_a[hi_idx];
      end
      OP_RCR: begin
        cf_out = s1_a[lo_idx];
        of_out = res_r[WIDTH-1] ^ res_r[WIDTH-2];
      end
      OP_SHL, OP_SAL: begin
        is_shift = 1'b1;
        cf_out   = (s1_cnt > W8) ? 1'b0 : s1_a[hi_idx];
        of_out   = res_r[WIDTH-1] ^ cf_out;
      end
      OP_SHR: begin
        is_shift = 1'b1;
        cf_out   = (s1_cnt > W8) ? 1'b0 : s1_a[lo_idx];
        of_out   = s1_a[WIDTH-1];
      end
      OP_SAR: begin
        is_shift = 1'b1;
        cf_out   = (s1_cnt > W8) ? s1_a[WIDTH-1] : s1_a[lo_idx];
        of_out   = 1'b0;
      end
    endcase
  end

  // Assemble {OF,SF,ZF,PF,CF} and the matching update mask
  always_comb begin
    flags_d = '0;
    fmask_d = '0;
    if (s1_cnt == '0) begin
      flags_d[0] = s1_cf;
    end else begin
      flags_d[0] = cf_out;
      fmask_d[0] = 1'b1;
      if (is_shift) begin
        flags_d[3]   = res_r[WIDTH-1];
        flags_d[2]   = (res_r == '0);
        flags_d[1]   = ~^res_r[7:0];
        fmask_d[3:1] = '1;
      end
      if (s1_cnt == 8'd1) begin
        flags_d[4] = of_out;
        fmask_d[4] = 1'b1;
      end
    end
  end
`else
  assign flags_d = '0;
  assign fmask_d = '0;
`endif

  // Stage 2 register: holds the result stable until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_flags <= '0;
      out_fmask <= '0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_r     <= res_r;
        out_flags <= flags_d;
        out_fmask <= fmask_d;
      end
    end
  end

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Self-checking bench for shift_rotate_unit (WIDTH=16): directed cases plus a
// randomized traffic phase scored against a bit-serial reference model.
module tb_shift_rotate_unit;

  localparam int unsigned W = 16;

`ifdef SHIFT_ROTATE_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] r;
    logic [4:0]   f;
    logic [4:0]   m;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [7:0]   in_cnt;
  logic         in_cf;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_r;
  logic [4:0]   out_flags;
  logic [4:0]   out_fmask;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned mon_sz;
  exp_t        exp_q[$];

  shift_rotate_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_op(in_op),
    .in_a(in_a),
    .in_cnt(in_cnt),
    .in_cf(in_cf),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_r(out_r),
    .out_flags(out_flags),
    .out_fmask(out_fmask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: perform the operation one single-bit step at a time
  function automatic exp_t ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [7:0] cnt, input logic cf);
    int unsigned n;
    logic [W-1:0] r;
    logic         c;
    logic         of_b;
    exp_t         e;
    r = a;
    c = cf;
    if (op == 3'd0 || op == 3'd1)      n = cnt % W;
    else if (op == 3'd2 || op == 3'd3) n = cnt % (W + 1);
    else                               n = (cnt > W + 1) ? W + 1 : cnt;
    for (int unsigned i = 0; i < n; i++) begin
      case (op)
        3'd0: begin c = r[W-1]; r = {r[W-2:0], r[W-1]}; end
        3'd1: begin c = r[0]; r = {r[0], r[W-1:1]}; end
        3'd2: {c, r} = {r, c};
        3'd3: {r, c} = {c, r};
        3'd4, 3'd6: {c, r} = {r, 1'b0};
        3'd5: {r, c} = {1'b0, r};
        default: {r, c} = {r[W-1], r};
      endcase
    end
    e.r = r;
    e.f = 5'b0;
    e.m = 5'b0;
    if (n == 0) begin
      e.f[0] = cf;
    end else begin
      e.f[0] = c;
      e.m[0] = 1'b1;
      if (op[2]) begin
        e.f[3] = r[W-1];
        e.f[2] = (r == 0);
        e.f[1] = ~^r[7:0];
        e.m[3:1] = 3'b111;
      end
      if (n == 1) begin
        case (op)
          3'd0, 3'd2, 3'd4, 3'd6: of_b = r[W-1] ^ c;
          3'd1, 3'd3:             of_b = r[W-1] ^ r[W-2];
          3'd5:                   of_b = a[W-1];
          default:                of_b = 1'b0;
        endcase
        e.f[4] = of_b;
        e.m[4] = 1'b1;
      end
    end
    if (!FLAGS_ON) begin
      e.f = 5'b0;
      e.m = 5'b0;
    end
    return e;
  endfunction

  // Scoreboard monitor: sampled just after the falling edge, i.e. with the
  // values the next rising edge will act on
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      mon_sz = exp_q.size();
      check("in_ready", in_ready, (mon_sz < 2) || out_ready);
      if (mon_sz == 2) check("full_valid", out_valid, 1);
      if (mon_sz == 0) begin
        check("spurious_valid", out_valid, 0);
      end else if (out_valid) begin
        check("out_r", out_r, exp_q[0].r);
        check("out_flags", out_flags, exp_q[0].f);
        check("out_fmask", out_fmask, exp_q[0].m);
        if (out_ready) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(in_op, in_a, in_cnt, in_cf));
    end
  end

  task automatic set_req(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [7:0] cnt, input logic cf);
    in_op    = op;
    in_a     = a;
    in_cnt   = cnt;
    in_cf    = cf;
    in_valid = 1'b1;
  endtask

  // One isolated request against spec-derived constants, with latency check
  task automatic directed(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [7:0] cnt, input logic cf, input logic [W-1:0] er,
                          input logic [4:0] ef, input logic [4:0] em);
    @(negedge clk);
    set_req(op, a, cnt, cf);
    #2 check({tag, "_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #2 check({tag, "_early"}, out_valid, 0);
    @(negedge clk);
    #2;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_r"}, out_r, er);
    check({tag, "_flags"}, out_flags, FLAGS_ON ? ef : 5'b0);
    check({tag, "_fmask"}, out_fmask, FLAGS_ON ? em : 5'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned sel;
    int unsigned guard;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_a      = '0;
    in_cnt    = '0;
    in_cf     = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_r", out_r, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_out_fmask", out_fmask, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rst_ready", in_ready, 1);

    directed("rol1",   3'b000, 16'h8001, 8'd1,   1'b0, 16'h0003, 5'b10001, 5'b10001);
    directed("shr16",  3'b101, 16'h8000, 8'd16,  1'b0, 16'h0000, 5'b00111, 5'b01111);
    directed("shr17",  3'b101, 16'h8000, 8'd17,  1'b0, 16'h0000, 5'b00110, 5'b01111);
    directed("sar4",   3'b111, 16'h8000, 8'd4,   1'b0, 16'hF800, 5'b01010, 5'b01111);
    directed("rcr17",  3'b011, 16'h0001, 8'd17,  1'b1, 16'h0001, 5'b00001, 5'b00000);
    directed("rcr1",   3'b011, 16'h0001, 8'd1,   1'b1, 16'h8000, 5'b10001, 5'b10001);
    directed("shl0",   3'b100, 16'h1234, 8'd0,   1'b1, 16'h1234, 5'b00001, 5'b00000);
    directed("rol16",  3'b000, 16'hABCD, 8'd16,  1'b0, 16'hABCD, 5'b00000, 5'b00000);
    directed("rcl18",  3'b010, 16'h8000, 8'd18,  1'b0, 16'h0000, 5'b10001, 5'b10001);
    directed("sar200", 3'b111, 16'h8000, 8'd200, 1'b0, 16'hFFFF, 5'b01011, 5'b01111);

    // Back-pressure: two requests fill the pipe, the third must stall
    @(negedge clk);
    out_ready = 1'b0;
    set_req(3'b000, 16'h0001, 8'd1, 1'b0);
    #2 check("bp_ready_a", in_ready, 1);
    @(negedge clk);
    set_req(3'b100, 16'h0003, 8'd2, 1'b0);
    #2 check("bp_ready_b", in_ready, 1);
    @(negedge clk);
    set_req(3'b111, 16'hF000, 8'd3, 1'b0);
    #2 check("bp_ready_c", in_ready, 0);
    repeat (3) @(negedge clk);
    #2 check("bp_hold_ready", in_ready, 0);
    @(negedge clk);
    out_ready = 1'b1;
    #2 check("bp_burst0", out_valid, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #2 check("bp_burst1", out_valid, 1);
    @(negedge clk);
    #2 check("bp_burst2", out_valid, 1);
    @(negedge clk);
    #2 check("bp_empty", out_valid, 0);

    // Asynchronous reset with two operations in flight
    @(negedge clk);
    out_ready = 1'b0;
    set_req(3'b001, 16'h00F0, 8'd4, 1'b0);
    @(negedge clk);
    set_req(3'b010, 16'h0F00, 8'd3, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_out_r", out_r, 0);
    exp_q.delete();
    @(negedge clk);
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1 check("arst_ready_after", in_ready, 1);
    repeat (2) begin
      @(negedge clk);
      #2 check("arst_no_stale", out_valid, 0);
    end
    directed("after_rst", 3'b110, 16'h4001, 8'd1, 1'b0, 16'h8002, 5'b11000, 5'b11111);

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 70);
      in_op     = 3'($urandom_range(0, 7));
      in_cf     = 1'($urandom_range(0, 1));
      sel       = $urandom_range(0, 9);
      case (sel)
        0: in_cnt = 8'd0;
        1: in_cnt = 8'd1;
        2: in_cnt = 8'(W - 1);
        3: in_cnt = 8'(W);
        4: in_cnt = 8'(W + 1);
        5: in_cnt = 8'(W + 2);
        6: in_cnt = 8'd255;
        default: in_cnt = 8'($urandom_range(0, 255));
      endcase
      sel = $urandom_range(0, 7);
      case (sel)
        0: in_a = '0;
        1: in_a = '1;
        2: in_a = 16'h8000;
        default: in_a = 16'($urandom());
      endcase
    end

    // Drain with a bounded wait
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #2;
    check("drain_pending", exp_q.size(), 0);
    check("drain_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
